// File: rtl/bus_fifo_port.sv
// Memory-mapped FIFO port for the OISC data bus: DATA/STATUS/RX_COUNT/TX_COUNT
// registers bridging the core to a TX and an RX 16-bit valid/ready stream.
module bus_fifo_port #(
    parameter int unsigned DEPTH = 8,
    parameter logic [15:0] BASE  = 16'h8010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_addr,
    input  logic        bus_w_en,
    input  logic [15:0] bus_d_in,
    output logic [15:0] bus_d_out,
    output logic        bus_rdy,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [15:0]   tx_mem_q [DEPTH];
    logic [15:0]   rx_mem_q [DEPTH];
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic          rdy_q, rdy_d;
    logic [15:0]   dout_q, dout_d;
    logic [0:0]    state_q, state_d;

    logic [15:0] off;
    logic [1:0]  sel;
    logic        access, data_wr, data_rd, stat_rd;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [15:0] status;

    always_comb begin
        off      = bus_addr - BASE;
        sel      = off[1:0];
        access   = (state_q == S_IDLE) && (off < 16'd4);
        data_wr  = access && bus_w_en && (sel == 2'd0);
        data_rd  = access && !bus_w_en && (sel == 2'd0);
        stat_rd  = access && !bus_w_en && (sel == 2'd1);
        tx_empty = (tx_cnt_q == '0);
        tx_full  = (tx_cnt_q == FULL_CNT);
        rx_empty = (rx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FULL_CNT);
        tx_pop   = !tx_empty && tx_ready;
        // A same-edge stream pop frees a slot, so a push to a full TX still lands.
        tx_push  = data_wr && (!tx_full || tx_pop);
        rx_push  = rx_valid && rx_ready;
        rx_pop   = data_rd && !rx_empty;
        status   = {10'b0, rx_unf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
    end

    always_comb begin
        state_d  = (state_q == S_IDLE && access) ? S_ACK : S_IDLE;
        rdy_d    = access;
        tx_wr_d  = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + PTR_ONE : tx_rd_q;
        rx_wr_d  = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        // Set wins over a same-edge STATUS read clear.
        tx_ovf_d = (tx_ovf_q && !stat_rd) || (data_wr && !tx_push);
        rx_unf_d = (rx_unf_q && !stat_rd) || (data_rd && rx_empty);
        dout_d   = dout_q;
        if (access && !bus_w_en) begin
            case (sel)
                2'd0:    dout_d = rx_empty ? '0 : rx_mem_q[rx_rd_q];
                2'd1:    dout_d = status;
                2'd2:    dout_d = 16'(rx_cnt_q);
                default: dout_d = 16'(tx_cnt_q);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_q    <= 1'b0;
            dout_q   <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            dout_q   <= dout_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= bus_d_in;
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data;
    end

    // Storage is not reset, so the head is masked to zero while TX is empty.
    assign tx_data   = tx_empty ? '0 : tx_mem_q[tx_rd_q];
    assign tx_valid  = !tx_empty;
    assign rx_ready  = rst_n && !rx_full;
    assign bus_rdy   = rdy_q;
    assign bus_d_out = dout_q;

endmodule

// File: tb/tb_bus_fifo_port.sv
// Self-checking bench for bus_fifo_port: register-access table, TX/RX models
// and a read-data scoreboard, plus sequences for full/empty/reset corners.
module tb_bus_fifo_port;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] BASE  = 16'h8010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus_addr = '0;
    logic        bus_w_en = 1'b0;
    logic [15:0] bus_d_in = '0;
    logic [15:0] bus_d_out;
    logic        bus_rdy;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    bus_fifo_port #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_addr(bus_addr), .bus_w_en(bus_w_en), .bus_d_in(bus_d_in),
        .bus_d_out(bus_d_out), .bus_rdy(bus_rdy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb[$];
    logic [15:0] txm[$];
    logic [15:0] rxm[$];

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] din;
        logic        hit;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got nothing expected a model entry", name);
    endtask

    task automatic do_access(input logic [15:0] a, input logic w, input logic [15:0] d,
                             input logic exp_hit, input logic [15:0] exp_rd,
                             input bit pop_tx, input string name);
        logic [15:0] e;
        @(negedge clk);
        bus_addr = a; bus_w_en = w; bus_d_in = d;
        if (pop_tx) begin
            tx_ready = 1'b1;
            check({name, "_txv"}, tx_valid, 1);
            if (txm.size() == 0) fail_note({name, "_txq"});
            else check({name, "_txd"}, tx_data, txm.pop_front());
        end
        if (exp_hit) begin
            if (!w) begin
                if (a == BASE) e = (rxm.size() > 0) ? rxm.pop_front() : 16'h0000;
                else e = exp_rd;
                sb.push_back(e);
            end else if (a == BASE && txm.size() < DEPTH) begin
                txm.push_back(d);
            end
        end
        @(negedge clk);
        tx_ready = 1'b0;
        check({name, "_rdy"}, bus_rdy, exp_hit);
        if (bus_rdy && !w) begin
            if (sb.size() == 0) fail_note({name, "_sb"});
            else check({name, "_dout"}, bus_d_out, sb.pop_front());
        end
        bus_addr = 16'h0000; bus_w_en = 1'b0;
        @(negedge clk);
        check({name, "_ack"}, bus_rdy, 0);
    endtask

    task automatic tx_drain(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            check({name, "_v"}, tx_valid, 1);
            if (txm.size() == 0) fail_note({name, "_q"});
            else check({name, "_d"}, tx_data, txm.pop_front());
        end
        @(negedge clk);
        tx_ready = 1'b0;
        check({name, "_end_v"}, tx_valid, (txm.size() != 0) ? 16'd1 : 16'd0);
    endtask

    task automatic reset_checks(input string name);
        check({name, "_rdy"}, bus_rdy, 0);
        check({name, "_dout"}, bus_d_out, 0);
        check({name, "_txv"}, tx_valid, 0);
        check({name, "_txd"}, tx_data, 0);
        check({name, "_rxr"}, rx_ready, 0);
        sb.delete(); txm.delete(); rxm.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h8010, 1'b1, 16'h1234, 1'b1, 16'h0000, "wr_1234"};
        vecs[1] = '{16'h8010, 1'b1, 16'hABCD, 1'b1, 16'h0000, "wr_abcd"};
        vecs[2] = '{16'h8013, 1'b0, 16'h0000, 1'b1, 16'h0002, "txcnt_2"};
        vecs[3] = '{16'h8011, 1'b0, 16'h0000, 1'b1, 16'h0004, "stat_a"};
        vecs[4] = '{16'h8012, 1'b0, 16'h0000, 1'b1, 16'h0000, "rxcnt_0"};
        vecs[5] = '{16'h8011, 1'b1, 16'hFFFF, 1'b1, 16'h0000, "wr_stat"};
        vecs[6] = '{16'h8013, 1'b1, 16'h0005, 1'b1, 16'h0000, "wr_txcnt"};
        vecs[7] = '{16'h8013, 1'b0, 16'h0000, 1'b1, 16'h0002, "txcnt_2b"};
        vecs[8] = '{16'h8014, 1'b0, 16'h0000, 1'b0, 16'h0000, "miss_hi"};
        vecs[9] = '{16'h800F, 1'b0, 16'h0000, 1'b0, 16'h0000, "miss_lo"};

        repeat (3) @(negedge clk);
        reset_checks("rst0");
        rst_n = 1'b1;
        #1 check("rst0_rel_rxr", rx_ready, 1);

        for (int i = 0; i < 10; i++)
            do_access(vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].hit, vecs[i].exp, 1'b0, vecs[i].name);
        check("head_1234", tx_data, 16'h1234);
        tx_drain(2, "drain2");

        for (int i = 1; i <= 9; i++)
            do_access(BASE, 1'b1, 16'h0100 + 16'(i), 1'b1, 16'h0000, 1'b0, "fill");
        do_access(16'h8013, 1'b0, '0, 1'b1, 16'h0008, 1'b0, "ovf_cnt");
        do_access(16'h8011, 1'b0, '0, 1'b1, 16'h0016, 1'b0, "ovf_stat1");
        do_access(16'h8011, 1'b0, '0, 1'b1, 16'h0006, 1'b0, "ovf_stat2");

        do_access(BASE, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 1'b1, "full_pushpop");
        do_access(16'h8013, 1'b0, '0, 1'b1, 16'h0008, 1'b0, "pp_cnt");
        do_access(16'h8011, 1'b0, '0, 1'b1, 16'h0006, 1'b0, "pp_stat");
        tx_drain(8, "wrap_drain");

        do_access(BASE, 1'b0, '0, 1'b1, 16'h0000, 1'b0, "unf_rd");
        do_access(16'h8011, 1'b0, '0, 1'b1, 16'h0025, 1'b0, "unf_stat1");
        do_access(16'h8011, 1'b0, '0, 1'b1, 16'h0005, 1'b0, "unf_stat2");

        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("rx_in_rdy", rx_ready, 1);
            rx_valid = 1'b1;
            rx_data  = 16'(i);
            rxm.push_back(16'(i));
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check("rx_full_rdy", rx_ready, 0);
        do_access(16'h8012, 1'b0, '0, 1'b1, 16'h0008, 1'b0, "rx_cnt8");
        do_access(16'h8011, 1'b0, '0, 1'b1, 16'h0009, 1'b0, "rx_stat");
        do_access(BASE, 1'b0, '0, 1'b1, 16'h0000, 1'b0, "rx_rd");
        check("rx_rdy_back", rx_ready, 1);
        for (int i = 0; i < 7; i++)
            do_access(BASE, 1'b0, '0, 1'b1, 16'h0000, 1'b0, "rx_rd");

        do_access(BASE, 1'b1, 16'h5555, 1'b1, 16'h0000, 1'b0, "pre_rst_wr");
        do_access(16'h8013, 1'b0, '0, 1'b1, 16'h0001, 1'b0, "pre_rst_cnt");
        @(negedge clk);
        bus_addr = BASE; bus_w_en = 1'b1; bus_d_in = 16'h7777;
        #2 rst_n = 1'b0;
        @(negedge clk);
        reset_checks("rst_mid");
        bus_addr = 16'h0000; bus_w_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_mid_rel_rxr", rx_ready, 1);
        do_access(16'h8013, 1'b0, '0, 1'b1, 16'h0000, 1'b0, "post_rst_txcnt");
        do_access(16'h8011, 1'b0, '0, 1'b1, 16'h0005, 1'b0, "post_rst_stat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
